// File: rtl/fp_add_sched_pkg.sv
// Shared types and constants for the shared FP adder scheduler.
package fp_add_sched_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ID_W_MAX   = 3;

    localparam logic SYM_ADD = 1'b0;
    localparam logic SYM_SUB = 1'b1;

    localparam logic [DATA_WIDTH-1:0] FP_ONE   = 32'h3F800000;
    localparam logic [DATA_WIDTH-1:0] FP_TWO   = 32'h40000000;
    localparam logic [DATA_WIDTH-1:0] FP_THREE = 32'h40400000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  symbol;
        logic [ID_W_MAX-1:0]   id;
    } operand_t;

endpackage

// File: rtl/fp_add_scheduler_if.sv
// Request/response channels between FPU front-end ports and the adder scheduler.
interface fp_add_scheduler_if
    import fp_add_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*DATA_WIDTH-1:0] req_a;
    logic [N_REQ*DATA_WIDTH-1:0] req_b;
    logic [N_REQ-1:0]            req_symbol;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [DATA_WIDTH-1:0]       rsp_data;
    logic [ID_W-1:0]             rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_symbol, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_symbol, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/ADD_CLA_FINAL.sv
// Combinational IEEE-754 single-precision add/sub, round-to-nearest-even.
module ADD_CLA_FINAL (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        symbol,
    output logic [31:0] out
);
    logic        sa, sb, swap, eff_sub, big_s;
    logic [23:0] ma, mb, big_m, sm_m;
    logic [7:0]  xa, xb, big_e, sm_e, d;
    logic [26:0] sm_ext, sm_al, norm;
    logic [27:0] sum;
    logic [24:0] mant;
    logic [9:0]  e;
    logic [31:0] res;
    logic        a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        sa      = a[31];
        sb      = b[31] ^ symbol;
        ma      = {|a[30:23], a[22:0]};
        mb      = {|b[30:23], b[22:0]};
        xa      = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        xb      = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        swap    = b[30:0] > a[30:0];
        big_s   = swap ? sb : sa;
        big_e   = swap ? xb : xa;
        big_m   = swap ? mb : ma;
        sm_e    = swap ? xa : xb;
        sm_m    = swap ? ma : mb;
        eff_sub = sa ^ sb;
        d       = big_e - sm_e;
        sm_ext  = {sm_m, 3'b000};
        // Align the smaller operand, folding shifted-out bits into sticky
        if (d > 8'd26) begin
            sm_al = {26'd0, |sm_m};
        end else begin
            sm_al    = sm_ext >> d;
            sm_al[0] = sm_al[0] | (|(sm_ext & ((27'd1 << d) - 27'd1)));
        end
        sum = eff_sub ? ({1'b0, big_m, 3'b000} - {1'b0, sm_al})
                      : ({1'b0, big_m, 3'b000} + {1'b0, sm_al});
        e = {2'b00, big_e};
        if (sum[27]) begin
            norm    = sum[27:1];
            norm[0] = norm[0] | sum[0];
            e       = e + 10'd1;
        end else begin
            norm = sum[26:0];
        end
        // Left-normalise, stopping at the subnormal exponent
        for (int i = 0; i < 27; i++) begin
            if (!norm[26] && e > 10'd1) begin
                norm = norm << 1;
                e    = e - 10'd1;
            end
        end
        mant = {1'b0, norm[26:3]} + 25'(norm[2] & (norm[1] | norm[0] | norm[3]));
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 10'd1;
        end
        res = {big_s, (mant[23] ? e[7:0] : 8'd0), mant[22:0]};
        if (e >= 10'd255) res = {big_s, 8'hFF, 23'd0};
        if (sum == 28'd0) res = {sa & sb, 31'd0};

        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && !(|a[22:0]);
        b_inf = (&b[30:23]) && !(|b[22:0]);
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) out = 32'h7FC00000;
        else if (a_inf)                                  out = {sa, 8'hFF, 23'd0};
        else if (b_inf)                                  out = {sb, 8'hFF, 23'd0};
        else                                             out = res;
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_grant
);
    logic [ID_W-1:0] idx;

    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = ptr + ID_W'(k);
            if (en && !any_grant && req[idx]) begin
                any_grant = 1'b1;
                grant_idx = idx;
            end
        end
        grant = any_grant ? (N_REQ'(1) << grant_idx) : '0;
    end
endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one FP add/sub unit among N_REQ requesters through a 2-stage pipeline
// with round-robin admission and an ID-tagged, backpressured response channel.
module fp_add_scheduler
    import fp_add_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ),
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    fp_add_scheduler_if.slave   bus,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);
    operand_t              s1;
    logic                  s1_v;
    logic                  s2_v;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       grant_idx;
    logic                  any_grant;
    logic                  adv1;
    logic                  adv2;
    logic [DATA_WIDTH-1:0] sum;

    assign adv2 = !s2_v || bus.rsp_ready;
    assign adv1 = !s1_v || adv2;

    // Grants are suppressed during reset so req_ready reads zero there
    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req       (bus.req_valid),
        .en        (adv1 && !rst),
        .ptr       (rr_ptr),
        .grant     (bus.req_ready),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    ADD_CLA_FINAL u_add (
        .a      (s1.a),
        .b      (s1.b),
        .symbol (s1.symbol),
        .out    (sum)
    );

    assign bus.rsp_valid = s2_v;
    assign busy          = s1_v | s2_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v         <= 1'b0;
            s2_v         <= 1'b0;
            rr_ptr       <= '0;
            bus.rsp_data <= '0;
            bus.rsp_id   <= '0;
            op_count     <= '0;
        end else begin
            if (adv1) begin
                s1_v <= any_grant;
                if (any_grant) begin
                    s1 <= '{a:      bus.req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH],
                            b:      bus.req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH],
                            symbol: bus.req_symbol[grant_idx],
                            id:     ID_W_MAX'(grant_idx)};
                    rr_ptr <= grant_idx + ID_W'(1);
                end
            end
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    bus.rsp_data <= sum;
                    bus.rsp_id   <= ID_W'(s1.id);
                end
            end
            if (s2_v && bus.rsp_ready) op_count <= op_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler: integer-valued FP operands, expected
// results computed exactly in the bench and matched in acceptance order.
module tb_fp_add_scheduler;
    import fp_add_sched_pkg::*;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    fp_add_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    fp_add_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   rem [N_REQ];
    int   cx  [N_REQ];
    int   cy  [N_REQ];
    logic cs  [N_REQ];
    bit   chk_lat;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Exact single-precision encoding of an integer with magnitude below 2^24
    function automatic logic [31:0] int2fp(input int v);
        logic [31:0] m;
        int          msb;
        if (v == 0) return 32'd0;
        m   = (v < 0) ? 32'(-v) : 32'(v);
        msb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) msb = i;
        return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + msb), 23'(m << (23 - msb))};
    endfunction

    task automatic drive();
        for (int i = 0; i < int'(N_REQ); i++) begin
            bus.req_valid[i]       = rem[i] > 0;
            bus.req_a[i*32 +: 32]  = int2fp(cx[i]);
            bus.req_b[i*32 +: 32]  = int2fp(cy[i]);
            bus.req_symbol[i]      = cs[i];
        end
    endtask

    task automatic new_op(input int i);
        cx[i] = int'($urandom_range(0, 999));
        cy[i] = int'($urandom_range(0, 999));
        cs[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic load(input int i, input int x, input int y, input logic s, input int n);
        cx[i]  = x;
        cy[i]  = y;
        cs[i]  = s;
        rem[i] = n;
        drive();
    endtask

    // One clock: observe at negedge, then update requesters just after posedge
    task automatic step(output int g, output bit hs);
        exp_t e;
        bit   r;
        @(negedge clk);
        g  = -1;
        hs = 1'b0;
        r  = rst;
        if (!r) begin
            if ((bus.req_ready & ~bus.req_valid) != '0)
                check_eq("ready_without_valid", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (bus.req_ready[i]) begin
                    g = i;
                    e.id   = i;
                    e.data = int2fp(cs[i] ? cx[i] - cy[i] : cx[i] + cy[i]);
                    e.cyc  = cyc;
                    sb.push_back(e);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                hs = 1'b1;
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rsp_id",   64'(bus.rsp_id),   64'(e.id));
                    check_eq("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                    if (chk_lat) check_eq("rsp_latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        if (r) sb.delete();
        if (g >= 0) begin
            rem[g]--;
            if (rem[g] > 0) new_op(g);
        end
        drive();
    endtask

    function automatic bit idle();
        bit any_rem = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) if (rem[i] > 0) any_rem = 1'b1;
        return !any_rem && (sb.size() == 0) && !busy;
    endfunction

    task automatic drain(input int bound);
        int g;
        bit h;
        for (int k = 0; k < bound; k++) begin
            if (idle()) break;
            step(g, h);
        end
        check_eq("drain_done", 64'(idle()), 64'd1);
    endtask

    task automatic do_reset();
        int g;
        bit h;
        for (int i = 0; i < int'(N_REQ); i++) rem[i] = 0;
        drive();
        rst = 1'b1;
        step(g, h);
        rst = 1'b0;
    endtask

    initial begin
        int g;
        bit h;
        int grants;
        logic [31:0]   hold_data;
        logic [ID_W-1:0] hold_id;

        chk_lat       = 1'b1;
        bus.rsp_ready = 1'b1;
        rst           = 1'b1;
        for (int i = 0; i < int'(N_REQ); i++) load(i, i, 1, SYM_ADD, 1);

        // Reset state, with every requester asserting valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_busy",      64'(busy),          64'd0);
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_op_count",  64'(op_count),      64'd0);
        check_eq("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
        check_eq("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N_REQ); i++) rem[i] = 0;
        drive();
        rst = 1'b0;

        // Single add 1.0 + 2.0 from requester 0
        load(0, 1, 2, SYM_ADD, 1);
        check_eq("fp_one_operand", 64'(bus.req_a[31:0]), 64'(FP_ONE));
        step(g, h);
        check_eq("add_grant", 64'(g), 64'd0);
        step(g, h);
        step(g, h);
        check_eq("add_rsp_seen", 64'(h), 64'd1);
        check_eq("add_op_count", 64'(op_count), 64'd1);

        // Subtract 3.0 - 1.0 from requester 2
        load(2, 3, 1, SYM_SUB, 1);
        step(g, h);
        check_eq("sub_grant", 64'(g), 64'd2);
        step(g, h);
        step(g, h);
        check_eq("sub_rsp_seen", 64'(h), 64'd1);
        check_eq("sub_rsp_data", 64'(bus.rsp_data), 64'(FP_TWO));
        drain(10);

        // Fairness: all four requesters streaming two ops each
        do_reset();
        for (int i = 0; i < int'(N_REQ); i++) begin
            rem[i] = 2;
            new_op(i);
        end
        drive();
        for (int k = 0; k < 8; k++) begin
            step(g, h);
            check_eq("fair_grant", 64'(g), 64'(k % 4));
            if (k >= 2) check_eq("fair_no_bubble", 64'(h), 64'd1);
        end
        drain(20);

        // Backpressure: requester 1 streams while the consumer stalls
        bus.rsp_ready = 1'b0;
        chk_lat       = 1'b0;
        grants        = 0;
        hold_data     = '0;
        hold_id       = '0;
        rem[1]        = 6;
        new_op(1);
        drive();
        for (int k = 0; k < 5; k++) begin
            step(g, h);
            if (g >= 0) grants++;
            if (k == 1) begin
                hold_data = bus.rsp_data;
                hold_id   = bus.rsp_id;
            end else if (k > 1) begin
                check_eq("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                check_eq("bp_data_hold", 64'(bus.rsp_data), 64'(hold_data));
                check_eq("bp_id_hold",   64'(bus.rsp_id),   64'(hold_id));
            end
        end
        check_eq("bp_accepted",   64'(grants),        64'd2);
        check_eq("bp_ready_zero", 64'(bus.req_ready), 64'd0);
        bus.rsp_ready = 1'b1;
        drain(40);
        chk_lat = 1'b1;

        // Reset one cycle after a grant discards the operation
        load(1, 7, 5, SYM_ADD, 1);
        step(g, h);
        check_eq("midrst_grant", 64'(g), 64'd1);
        rst = 1'b1;
        step(g, h);
        rst = 1'b0;
        check_eq("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("midrst_busy",      64'(busy),          64'd0);
        check_eq("midrst_op_count",  64'(op_count),      64'd0);
        for (int i = 0; i < int'(N_REQ); i++) begin
            rem[i] = 1;
            new_op(i);
        end
        drive();
        step(g, h);
        check_eq("midrst_ptr_zero", 64'(g), 64'd0);
        drain(20);

        // Counter wrap
        do_reset();
        rem[3] = 65535;
        new_op(3);
        drive();
        drain(70000);
        check_eq("wrap_max", 64'(op_count), 64'hFFFF);
        rem[3] = 1;
        new_op(3);
        drive();
        drain(10);
        check_eq("wrap_zero", 64'(op_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fp_add_scheduler.md
Name: fp_add_scheduler

Overview:
- Shares one combinational single-precision IEEE-754 add/sub unit (ADD_CLA_FINAL: ports a, b, symbol, out) between N_REQ requesters.
- Round-robin arbiter admits one operation per cycle into a 2-stage register pipeline: operand register, then result register.
- Results return on a single response channel tagged with the requester ID, with valid/ready backpressure.
- Sits between the FPU front-end ports and the shared adder datapath.

Parameters:
- N_REQ, 4, number of requesters (power of two, 2..8).
- ID_W, $clog2(N_REQ), width of the requester tag.
- DATA_WIDTH, 32, operand and result width (IEEE-754 single).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester accept (grant).
- req_a  in  N_REQ*DATA_WIDTH  operand A, requester i at bits [i*32 +: 32].
- req_b  in  N_REQ*DATA_WIDTH  operand B, same packing.
- req_symbol  in  N_REQ  0 = A+B, 1 = A-B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DATA_WIDTH  result word.
- rsp_id  out  ID_W  index of the requester that issued the result.
- busy  out  1  any stage holds a valid operation.
- op_count  out  CNT_W  number of completed response handshakes.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). When rst is high at a clk edge: s1_v=0, s2_v=0, rr_ptr=0, rsp_data=0, rsp_id=0, op_count=0. Consequently rsp_valid=0, busy=0 and req_ready=0.
- Reset mid-operation discards all in-flight operations. No response is produced for them.
- Stage 2 (result register) can load when adv2 = !s2_v | rsp_ready.
- Stage 1 (operand register) can load when adv1 = !s1_v | adv2.
- Arbiter is enabled only when adv1=1. It scans req_valid starting at index rr_ptr, wrapping modulo N_REQ. The first valid index g gets req_ready[g]=1. All other req_ready bits are 0.
- req_ready is combinational from req_valid, rr_ptr and the stall terms. It never depends on the requester's own ready.
- On a grant at an edge:
  - s1 loads {a, b, symbol, id=g} and s1_v=1.
  - rr_ptr becomes (g+1) mod N_REQ.
  - With no grant, rr_ptr holds.
- If adv1=1 with no grant, s1_v becomes 0.
- On an edge with adv2=1:
  - s2 loads the adder output computed from s1's operands, plus s1's id.
  - s2_v takes s1_v.
  - When s1_v=0, rsp_data and rsp_id hold their values.
- Latency: handshake at edge E, s1 loaded at E, s2 loaded at E+1, rsp_valid high from E+1 onward. Throughput is 1 operation per cycle with no stalls.
- rsp_valid = s2_v. While rsp_valid=1 and rsp_ready=0:
  - rsp_data and rsp_id are held stable.
  - s1 holds its contents.
  - If s1_v=1, req_ready is all zero.
- Simultaneous rsp handshake and new grant in the same cycle is legal. The pipeline advances with no bubble.
- Requester protocol: req_valid and that requester's operands are held stable until req_ready. Dropping req_valid before grant is allowed; no operation is recorded.
- op_count increments by 1 on each rsp_valid & rsp_ready edge. It wraps from 2^CNT_W-1 to 0.
- busy = s1_v | s2_v.
- The adder's special-case and rounding behaviour passes through unchanged. The scheduler never inspects the data.
- Results always return in acceptance order. No reordering occurs.

Decomposition:
- Package fp_add_sched_pkg:
  - DATA_WIDTH.
  - SYM_ADD=1'b0, SYM_SUB=1'b1.
  - FP constants for benches: FP_ONE=32'h3F800000, FP_TWO=32'h40000000, FP_THREE=32'h40400000.
  - Operand struct {a, b, symbol, id}.
- One sub-module: rr_arbiter.
  - Parameter N_REQ.
  - Inputs: req, en, ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - The top level holds rr_ptr and both pipeline stages, and instantiates ADD_CLA_FINAL once.

Test Plan:
- Single add: req 0 sends a=0x3F800000, b=0x40000000, symbol=0, rsp_ready=1. Required: req_ready[0]=1 that cycle; rsp_valid 2 edges later with rsp_data=0x40400000, rsp_id=0; op_count=1.
- Subtract: req 2 sends a=0x40400000, b=0x3F800000, symbol=1. Required: rsp_data=0x40000000, rsp_id=2.
- Fairness: all 4 req_valid held high for 8 cycles, rsp_ready=1, rr_ptr=0 after reset. Required: grants 0,1,2,3,0,1,2,3 on consecutive cycles; rsp_id sequence matches; no bubbles.
- Backpressure: stream from req 1 with rsp_ready=0 for 5 cycles. Required:
  - Exactly 2 operations accepted, then req_ready=0.
  - rsp_data and rsp_id stable throughout.
  - After rsp_ready=1, the results drain in order with no loss or duplication.
- Reset mid-op: assert rst one cycle after a grant. Required: next cycle rsp_valid=0, busy=0, op_count=0, rr_ptr=0; no response ever appears for the discarded operation.
- Counter wrap: force 65536 completions. Required: op_count reads 0xFFFF, then 0x0000 on the next handshake.
